// File: rtl/axis_demux_n.sv
// axis_demux_n: AXI-Stream 1-to-N packet demux (per-packet dest lock via sel, out-of-range drop with saturating drop_cnt, busy while LOCKED, 2-entry skid output stage driving replicated m_axis_tdata/tlast and per-port m_axis_tvalid)
module axis_demux_n #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [N_OUT*WIDTH-1:0] m_axis_tdata,
  output logic [N_OUT-1:0]       m_axis_tvalid,
  input  logic [N_OUT-1:0]       m_axis_tready,
  output logic [N_OUT-1:0]       m_axis_tlast,
  input  logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic [15:0]            drop_cnt
);
  localparam int IW = $clog2(N_OUT);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] cur_sel, dst;
  logic acc, drop, push, consume, skid_nx, ready;
  logic out_valid, skid_valid, out_last, skid_last;
  logic [WIDTH-1:0] out_data, skid_data;
  logic [IW-1:0] out_dst, skid_dst;
  assign dst = state == LOCKED ? cur_sel : sel;
  assign acc = s_axis_tvalid && ready;
  assign drop = acc && dst >= SEL_W'(N_OUT);
  assign push = acc && !drop;
  assign consume = out_valid && m_axis_tready[out_dst];
  assign skid_nx = skid_valid ? !consume : push && out_valid && !consume;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = acc ? (s_axis_tlast ? IDLE : LOCKED) : state;
  always_comb busy = state == LOCKED;
  always_ff @(posedge clk)
    if (rst) cur_sel <= '0;
    else if (acc && state == IDLE) cur_sel <= sel;
  always_ff @(posedge clk)
    if (rst) drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_dst <= '0;
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_dst <= '0;
      ready <= 1'b0;
    end else begin
      if (!out_valid || consume) begin
        out_valid <= skid_valid || push;
        if (skid_valid) begin
          out_data <= skid_data;
          out_last <= skid_last;
          out_dst <= skid_dst;
        end else if (push) begin
          out_data <= s_axis_tdata;
          out_last <= s_axis_tlast;
          out_dst <= dst[IW-1:0];
        end
      end
      if (!skid_valid && skid_nx) begin
        skid_data <= s_axis_tdata;
        skid_last <= s_axis_tlast;
        skid_dst <= dst[IW-1:0];
      end
      skid_valid <= skid_nx;
      ready <= !skid_nx;
    end
  end
  assign s_axis_tready = ready;
  assign m_axis_tdata = {N_OUT{out_data}};
  assign m_axis_tlast = {N_OUT{out_last}};
  for (genvar i = 0; i < N_OUT; i++) begin : g_valid
    assign m_axis_tvalid[i] = out_valid && out_dst == IW'(i);
  end
endmodule
